// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake and data-memory bus of the MEM-stage load/store controller.
// The controller uses the slave modport; the requester/memory side uses master.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqSigned;
  logic [ADDR_W-1:0] ReqAddr;
  logic [DATA_W-1:0] ReqWData;
  logic              RspValid;
  logic [DATA_W-1:0] RspData;
  logic              RspError;
  logic              MemoryRead;
  logic              MemoryWrite;
  logic [ADDR_W-3:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
    output ReqReady, RspValid, RspData, RspError, MemoryRead, MemoryWrite, Address, WriteData
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
    input  ReqReady, RspValid, RspData, RspError, MemoryRead, MemoryWrite, Address, WriteData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store controller for a single-port 64x32 data memory.
// Sub-word stores are done as read-modify-write; loads sign/zero-extend the addressed lane.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic             Clock,
  input  logic             ResetN,
  mem_access_ctrl_if.slave bus
);
  localparam int WA_W = ADDR_W - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    LD_DONE = 3'd2,
    MERGE   = 3'd3,
    WR      = 3'd4,
    ST_DONE = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t            state_q;
  logic              write_q;
  logic              signed_q;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic [WA_W-1:0]   addr_q;
  logic [DATA_W-1:0] st_data_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              req_err_d;
  logic [7:0]        byte_sel_d;
  logic [15:0]       half_sel_d;
  logic [DATA_W-1:0] load_data_d;
  logic [DATA_W-1:0] merge_data_d;

  always_comb begin
    req_err_d = 1'b0;
    case (bus.ReqSize)
      2'b00:   req_err_d = 1'b0;
      2'b01:   req_err_d = bus.ReqAddr[0];
      2'b10:   req_err_d = |bus.ReqAddr[1:0];
      default: req_err_d = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel_d  = bus.ReadData[{lane_q, 3'b000} +: 8];
    half_sel_d  = bus.ReadData[{lane_q[1], 4'b0000} +: 16];
    load_data_d = bus.ReadData;
    case (size_q)
      2'b00:   load_data_d = {{(DATA_W-8){signed_q & byte_sel_d[7]}}, byte_sel_d};
      2'b01:   load_data_d = {{(DATA_W-16){signed_q & half_sel_d[15]}}, half_sel_d};
      default: load_data_d = bus.ReadData;
    endcase
  end

  // Only byte and half stores ever reach MERGE, so anything not a byte is a half.
  always_comb begin
    merge_data_d = bus.ReadData;
    if (size_q == 2'b00) begin
      merge_data_d[{lane_q, 3'b000} +: 8] = st_data_q[7:0];
    end else begin
      merge_data_d[{lane_q[1], 4'b0000} +: 16] = st_data_q[15:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      signed_q  <= 1'b0;
      size_q    <= 2'b00;
      lane_q    <= 2'b00;
      addr_q    <= '0;
      st_data_q <= '0;
      wr_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ReqValid) begin
            write_q   <= bus.ReqWrite;
            signed_q  <= bus.ReqSigned;
            size_q    <= bus.ReqSize;
            lane_q    <= bus.ReqAddr[1:0];
            addr_q    <= bus.ReqAddr[ADDR_W-1:2];
            st_data_q <= bus.ReqWData;
            if (req_err_d) begin
              state_q <= ERR;
            end else if (bus.ReqWrite && bus.ReqSize == 2'b10) begin
              wr_data_q <= bus.ReqWData;
              state_q   <= WR;
            end else begin
              state_q <= RD;
            end
          end
        end
        RD:      state_q <= write_q ? MERGE : LD_DONE;
        LD_DONE: state_q <= IDLE;
        MERGE: begin
          wr_data_q <= merge_data_d;
          state_q   <= WR;
        end
        WR:      state_q <= ST_DONE;
        ST_DONE: state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Enables are gated by ResetN so a reset asserted mid-operation kills them immediately.
  assign bus.ReqReady    = (state_q == IDLE);
  assign bus.MemoryRead  = ResetN && (state_q == RD);
  assign bus.MemoryWrite = ResetN && (state_q == WR);
  assign bus.RspValid    = ResetN && ((state_q == LD_DONE) || (state_q == ST_DONE) || (state_q == ERR));
  assign bus.RspError    = ResetN && (state_q == ERR);
  assign bus.RspData     = (ResetN && (state_q == LD_DONE)) ? load_data_d : '0;
  assign bus.Address     = addr_q;
  assign bus.WriteData   = wr_data_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a 64x32 memory model, a cycle-level reference model checked
// every cycle, and directed requests with hand-computed expectations.
module tb_mem_access_ctrl;
  logic Clock = 1'b0;
  logic ResetN;

  mem_access_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [64] = '{default: 32'h0};

  always @(negedge Clock) if (bus.MemoryWrite) mem[bus.Address] <= bus.WriteData;
  always @(posedge Clock) if (bus.MemoryRead) bus.ReadData <= mem[bus.Address];

  int nchk = 0;
  int nfail = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic int lane_shift(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'd0) ? 8 * int'(a[1:0]) : (sz == 2'd1) ? 16 * int'(a[1]) : 0;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic sg, input logic [7:0] a);
    logic [31:0] m, v;
    m = lane_mask(sz);
    v = (w >> lane_shift(sz, a)) & m;
    if (sg && sz != 2'd2 && (v & (m & ~(m >> 1))) != 0) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [7:0] a);
    logic [31:0] m;
    m = lane_mask(sz);
    return (w & ~(m << lane_shift(sz, a))) | ((wd & m) << lane_shift(sz, a));
  endfunction

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge Clock);
    bus.ReqWrite = w; bus.ReqSize = sz; bus.ReqSigned = sg;
    bus.ReqAddr = a;  bus.ReqWData = wd; bus.ReqValid = 1'b1;
    n = 0;
    while (!bus.ReqReady && n < 20) begin @(negedge Clock); n++; end
    @(posedge Clock);
    @(negedge Clock);
    bus.ReqValid = 1'b0;
    lat = 1;
    while (!bus.RspValid && lat < 10) begin @(negedge Clock); lat++; end
    rd = bus.RspData;
    er = bus.RspError;
  endtask

  initial begin
    ResetN = 1'b0;
    bus.ReqValid = 1'b0; bus.ReqWrite = 1'b0; bus.ReqSize = 2'd0;
    bus.ReqSigned = 1'b0; bus.ReqAddr = 8'h0; bus.ReqWData = 32'h0;
    fork
      // Reference model: tracks the outstanding request and when each effect is due.
      begin : model
        logic [31:0] ref_mem [64];
        int cyc, prev, rd_c, wr_c, rsp_c;
        bit have, e_rd, e_wr, e_rsp;
        logic [5:0] m_word;
        logic [31:0] m_wdata, m_rdata;
        logic m_err, m_store;
        logic [7:0] a;
        logic [1:0] sz;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        cyc = 0; have = 0; rd_c = -100; wr_c = -100; rsp_c = -100;
        m_word = 0; m_wdata = 0; m_rdata = 0; m_err = 0; m_store = 0;
        forever begin
          @(posedge Clock);
          if (ResetN && bus.ReqValid && bus.ReqReady) acc_cnt++;
          prev = cyc;
          cyc++;
          if (!ResetN) begin
            have = 0;
          end else if (bus.ReqValid && !(have && prev <= rsp_c)) begin
            a = bus.ReqAddr; sz = bus.ReqSize;
            have = 1; rd_c = -100; wr_c = -100;
            m_word = a[7:2]; m_store = bus.ReqWrite; m_rdata = 32'h0;
            m_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
            if (m_err) begin
              rsp_c = cyc;
            end else if (!m_store) begin
              rd_c = cyc; rsp_c = cyc + 1;
              m_rdata = extract(ref_mem[m_word], sz, bus.ReqSigned, a);
            end else if (sz == 2'd2) begin
              wr_c = cyc; rsp_c = cyc + 1; m_wdata = bus.ReqWData;
            end else begin
              rd_c = cyc; wr_c = cyc + 2; rsp_c = cyc + 3;
              m_wdata = merge(ref_mem[m_word], bus.ReqWData, sz, a);
            end
          end
          #2;
          e_rd  = ResetN && have && cyc == rd_c;
          e_wr  = ResetN && have && cyc == wr_c;
          e_rsp = ResetN && have && cyc == rsp_c;
          chk("ReqReady",    {31'b0, bus.ReqReady},    {31'b0, !(have && cyc <= rsp_c)});
          chk("MemoryRead",  {31'b0, bus.MemoryRead},  {31'b0, e_rd});
          chk("MemoryWrite", {31'b0, bus.MemoryWrite}, {31'b0, e_wr});
          chk("RspValid",    {31'b0, bus.RspValid},    {31'b0, e_rsp});
          if (e_rd || e_wr) chk("Address", {26'b0, bus.Address}, {26'b0, m_word});
          if (e_wr) begin
            chk("WriteData", bus.WriteData, m_wdata);
            ref_mem[m_word] = m_wdata;
          end
          if (e_rsp) begin
            rsp_cnt++;
            chk("RspData",  bus.RspData, m_rdata);
            chk("RspError", {31'b0, bus.RspError}, {31'b0, m_err});
          end
        end
      end
      begin : directed
        logic [31:0] rd;
        logic er;
        int lat, acc0, rsp0;
        repeat (3) @(negedge Clock);
        ResetN = 1'b1;
        chk("rst_ready",  {31'b0, bus.ReqReady}, 32'd1);
        chk("rst_addr",   {26'b0, bus.Address}, 32'd0);
        chk("rst_wdata",  bus.WriteData, 32'd0);
        chk("rst_rspdat", bus.RspData, 32'd0);
        chk("rst_rsperr", {31'b0, bus.RspError}, 32'd0);

        do_req(1, 2'd2, 0, 8'h10, 32'hDEADBEEF, rd, er, lat);
        $display("store word @10 lat=%0d err=%0d", lat, er);
        chk("sw_lat", lat, 32'd2); chk("sw_mem", mem[4], 32'hDEADBEEF);
        do_req(0, 2'd2, 0, 8'h10, 32'h0, rd, er, lat);
        $display("load word @10 -> %h lat=%0d", rd, lat);
        chk("lw_data", rd, 32'hDEADBEEF); chk("lw_lat", lat, 32'd2);

        do_req(1, 2'd2, 0, 8'h10, 32'h11223344, rd, er, lat);
        $display("store word @10 = 11223344 lat=%0d", lat);
        do_req(1, 2'd0, 0, 8'h12, 32'h123456AA, rd, er, lat);
        $display("store byte @12 lat=%0d mem4=%h", lat, mem[4]);
        chk("sb_lat", lat, 32'd4); chk("sb_mem", mem[4], 32'h11AA3344);
        chk("sb_rdata", rd, 32'h0);

        do_req(0, 2'd0, 1, 8'h12, 32'h0, rd, er, lat);
        $display("load sbyte @12 -> %h", rd);
        chk("lb_s", rd, 32'hFFFFFFAA);
        do_req(0, 2'd0, 0, 8'h12, 32'h0, rd, er, lat);
        $display("load ubyte @12 -> %h", rd);
        chk("lb_u", rd, 32'h000000AA);
        do_req(0, 2'd1, 1, 8'h12, 32'h0, rd, er, lat);
        $display("load shalf @12 -> %h", rd);
        chk("lh_s", rd, 32'h000011AA);
        do_req(0, 2'd1, 0, 8'h10, 32'h0, rd, er, lat);
        $display("load uhalf @10 -> %h", rd);
        chk("lh_u0", rd, 32'h00003344);

        do_req(1, 2'd1, 0, 8'h12, 32'hFFFF8001, rd, er, lat);
        $display("store half @12 lat=%0d mem4=%h", lat, mem[4]);
        chk("sh_mem", mem[4], 32'h80013344);
        do_req(0, 2'd1, 1, 8'h12, 32'h0, rd, er, lat);
        $display("load shalf @12 -> %h", rd);
        chk("lh_neg", rd, 32'hFFFF8001);
        do_req(0, 2'd0, 1, 8'h13, 32'h0, rd, er, lat);
        $display("load sbyte @13 -> %h", rd);
        chk("lb_neg", rd, 32'hFFFFFF80);

        do_req(0, 2'd2, 0, 8'h11, 32'h0, rd, er, lat);
        $display("load word @11 err=%0d lat=%0d", er, lat);
        chk("mis_w_err", {31'b0, er}, 32'd1); chk("mis_w_lat", lat, 32'd1); chk("mis_w_dat", rd, 32'd0);
        do_req(0, 2'd1, 0, 8'h13, 32'h0, rd, er, lat);
        $display("load half @13 err=%0d lat=%0d", er, lat);
        chk("mis_h_err", {31'b0, er}, 32'd1); chk("mis_h_lat", lat, 32'd1);
        do_req(0, 2'd3, 0, 8'h10, 32'h0, rd, er, lat);
        $display("load size3 @10 err=%0d lat=%0d", er, lat);
        chk("ill_err", {31'b0, er}, 32'd1); chk("ill_lat", lat, 32'd1);
        do_req(1, 2'd2, 0, 8'h12, 32'h55555555, rd, er, lat);
        $display("store word @12 err=%0d mem4=%h", er, mem[4]);
        chk("mis_st_err", {31'b0, er}, 32'd1); chk("mis_st_mem", mem[4], 32'h80013344);

        // Byte store interrupted by reset while in its merge cycle.
        @(negedge Clock);
        bus.ReqWrite = 1; bus.ReqSize = 2'd0; bus.ReqSigned = 0;
        bus.ReqAddr = 8'h10; bus.ReqWData = 32'h55; bus.ReqValid = 1;
        @(posedge Clock);
        @(negedge Clock); bus.ReqValid = 0;
        @(negedge Clock); ResetN = 0;
        @(negedge Clock);
        @(negedge Clock); ResetN = 1;
        @(negedge Clock);
        $display("reset mid-store: ready=%0d mem4=%h", bus.ReqReady, mem[4]);
        chk("rmo_ready", {31'b0, bus.ReqReady}, 32'd1);
        chk("rmo_mem", mem[4], 32'h80013344);

        acc0 = acc_cnt; rsp0 = rsp_cnt;
        bus.ReqWrite = 0; bus.ReqSize = 2'd2; bus.ReqAddr = 8'h10; bus.ReqValid = 1;
        repeat (12) @(posedge Clock);
        @(negedge Clock); bus.ReqValid = 0;
        repeat (6) @(negedge Clock);
        $display("back-to-back: accepts=%0d responses=%0d", acc_cnt - acc0, rsp_cnt - rsp0);
        chk("b2b_acc", acc_cnt - acc0, 32'd4);
        chk("b2b_rsp", rsp_cnt - rsp0, 32'd4);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end
endmodule
